// File: rtl/lsu_mem_ctrl_if.sv
// Bundle of the core-side request/response handshake and the data-memory bus
// for the load/store controller. The controller connects through the slave
// modport; the core and memory side (or a testbench) uses the master modport.
interface lsu_mem_ctrl_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;

    logic                  rsp_valid;
    logic [31:0]           rsp_rdata;
    logic                  rsp_err;

    logic                  mem_ren;
    logic                  mem_wen;
    logic [ADDR_WIDTH-1:0] mem_add;
    logic [31:0]           mem_datain;
    logic [31:0]           mem_dataout;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_dataout,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_ren, mem_wen, mem_add, mem_datain
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output mem_dataout,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_ren, mem_wen, mem_add, mem_datain
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer between the core memory stage and a word-wide data
// memory. Sub-word stores are done as read-modify-write because the memory
// only writes whole words. Lane order is big-endian within the word: byte
// offset k lives in bits [31-8k : 24-8k]. Misaligned or illegal-size accesses
// are answered with an error and never touch memory.
module lsu_mem_ctrl #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    lsu_mem_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RMW_RD,
        ST_WRITE,
        ST_RESP
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic                  req_ready;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  mem_ren;
    logic                  mem_wen;
    logic [ADDR_WIDTH-1:0] mem_add;
    logic [DATA_WIDTH-1:0] mem_datain;

    logic                  misaligned;
    logic [ADDR_WIDTH-1:0] aligned_addr;
    logic [4:0]            lane_shift;
    logic [DATA_WIDTH-1:0] lane_mask;
    logic [DATA_WIDTH-1:0] lane_data;
    logic [DATA_WIDTH-1:0] load_ext;
    logic [DATA_WIDTH-1:0] merged_word;

    assign aligned_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};

    // Lane position, load extraction/extension and store merge for the held access
    always_comb begin
        lane_shift = 5'd0;
        lane_mask  = '1;
        if (size_q == 2'd0) begin
            lane_shift = 5'd24 - {addr_q[1:0], 3'b000};
            lane_mask  = 32'h0000_00FF;
        end else if (size_q == 2'd1) begin
            lane_shift = addr_q[1] ? 5'd0 : 5'd16;
            lane_mask  = 32'h0000_FFFF;
        end
        lane_data = bus.mem_dataout >> lane_shift;
        case (size_q)
            2'd0:    load_ext = uns_q ? {24'h0, lane_data[7:0]}
                                      : {{24{lane_data[7]}}, lane_data[7:0]};
            2'd1:    load_ext = uns_q ? {16'h0, lane_data[15:0]}
                                      : {{16{lane_data[15]}}, lane_data[15:0]};
            default: load_ext = bus.mem_dataout;
        endcase
        merged_word = (bus.mem_dataout & ~(lane_mask << lane_shift))
                    | ((wdata_q & lane_mask) << lane_shift);
    end

    // Alignment check on the incoming request, used only at accept time
    always_comb begin
        misaligned = 1'b0;
        case (bus.req_size)
            2'd1:    misaligned = bus.req_addr[0];
            2'd2:    misaligned = (bus.req_addr[1:0] != 2'b00);
            2'd3:    misaligned = 1'b1;
            default: misaligned = 1'b0;
        endcase
    end

    // Next-state, datapath register updates and Moore outputs of the sequencer
    always_comb begin
        state_d    = state_q;
        size_d     = size_q;
        uns_d      = uns_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_rdata  = '0;
        rsp_err    = 1'b0;
        mem_ren    = 1'b0;
        mem_wen    = 1'b0;
        mem_add    = '0;
        mem_datain = '0;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) begin
                    size_d  = bus.req_size;
                    uns_d   = bus.req_unsigned;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    if (misaligned) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else if (!bus.req_we) begin
                        state_d = ST_LOAD;
                    end else if (bus.req_size == 2'd2) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_RMW_RD;
                    end
                end
            end
            ST_LOAD: begin
                mem_ren = 1'b1;
                mem_add = aligned_addr;
                rdata_d = load_ext;
                state_d = ST_RESP;
            end
            ST_RMW_RD: begin
                mem_ren = 1'b1;
                mem_add = aligned_addr;
                wdata_d = merged_word;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                mem_wen    = 1'b1;
                mem_add    = aligned_addr;
                mem_datain = wdata_q;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                rsp_rdata = rdata_q;
                rsp_err   = err_q;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously so an aborted access leaves no trace
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_rdata  = rsp_rdata;
    assign bus.rsp_err    = rsp_err;
    assign bus.mem_ren    = mem_ren;
    assign bus.mem_wen    = mem_wen;
    assign bus.mem_add    = mem_add;
    assign bus.mem_datain = mem_datain;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed testbench for lsu_mem_ctrl: a word-wide memory model with
// combinational read and posedge write, hand-computed expected values for
// loads, stores, error cases, back-to-back traffic and reset mid-access.
module tb_lsu_mem_ctrl;

    logic clk;
    logic rst_n;

    int n_checks;
    int n_fail;

    logic [31:0] mem [0:1023];

    lsu_mem_ctrl_if #(.ADDR_WIDTH(12)) bus ();

    lsu_mem_ctrl #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: combinational read of the addressed word
    assign bus.mem_dataout = mem[bus.mem_add[11:2]];

    // Memory model: whole-word write on the rising edge when enabled
    always @(posedge clk) begin
        if (bus.mem_wen) mem[bus.mem_add[11:2]] = bus.mem_datain;
    end

    // Count one comparison and report it when observed differs from expected
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Issue one access, follow it cycle by cycle up to its response, and
    // return which of the following cycles had mem_ren / mem_wen high
    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [11:0] addr, input logic [31:0] wdata,
                                 input int lat, input logic [31:0] exp_rdata,
                                 input logic exp_err, input string tag,
                                 output logic [2:0] ren_pat, output logic [2:0] wen_pat);
        ren_pat = 3'b000;
        wen_pat = 3'b000;
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        checkOutput({tag, "_ready_idle"}, {31'h0, bus.req_ready}, 32'h1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            ren_pat[c-1] = bus.mem_ren;
            wen_pat[c-1] = bus.mem_wen;
            checkOutput({tag, "_ren_wen_excl"}, {31'h0, bus.mem_ren & bus.mem_wen}, 32'h0);
            checkOutput({tag, "_ready_busy"}, {31'h0, bus.req_ready}, 32'h0);
            if (bus.mem_ren || bus.mem_wen)
                checkOutput({tag, "_mem_add"}, {20'h0, bus.mem_add}, {20'h0, addr[11:2], 2'b00});
            if (c < lat) begin
                checkOutput({tag, "_rsp_early"}, {31'h0, bus.rsp_valid}, 32'h0);
            end else begin
                checkOutput({tag, "_rsp_valid"}, {31'h0, bus.rsp_valid}, 32'h1);
                checkOutput({tag, "_rsp_rdata"}, bus.rsp_rdata, exp_rdata);
                checkOutput({tag, "_rsp_err"}, {31'h0, bus.rsp_err}, {31'h0, exp_err});
            end
        end
    endtask

    logic [2:0] ren_pat;
    logic [2:0] wen_pat;

    // Directed test sequence
    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[12'h100 >> 2] = 32'hA1B2_C3D4;
        mem[12'h104 >> 2] = 32'h1122_3344;

        rst_n            = 1'b0;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 12'h0;
        bus.req_wdata    = 32'h0;

        // Reset values
        #12;
        checkOutput("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
        checkOutput("rst_rsp_err", {31'h0, bus.rsp_err}, 32'h0);
        checkOutput("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        checkOutput("rst_mem_ren", {31'h0, bus.mem_ren}, 32'h0);
        checkOutput("rst_mem_wen", {31'h0, bus.mem_wen}, 32'h0);
        checkOutput("rst_mem_add", {20'h0, bus.mem_add}, 32'h0);
        checkOutput("rst_mem_datain", bus.mem_datain, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_ready_after", {31'h0, bus.req_ready}, 32'h1);

        // Loads of 0xA1B2C3D4 at 0x100
        applyStimulus(1'b0, 2'd0, 1'b0, 12'h101, 32'h0, 2, 32'hFFFF_FFB2, 1'b0, "lb_101", ren_pat, wen_pat);
        checkOutput("lb_101_ren_pat", {29'h0, ren_pat}, 32'h1);
        applyStimulus(1'b0, 2'd0, 1'b1, 12'h101, 32'h0, 2, 32'h0000_00B2, 1'b0, "lbu_101", ren_pat, wen_pat);
        applyStimulus(1'b0, 2'd0, 1'b0, 12'h103, 32'h0, 2, 32'hFFFF_FFD4, 1'b0, "lb_103", ren_pat, wen_pat);
        applyStimulus(1'b0, 2'd0, 1'b1, 12'h100, 32'h0, 2, 32'h0000_00A1, 1'b0, "lbu_100", ren_pat, wen_pat);
        applyStimulus(1'b0, 2'd2, 1'b0, 12'h100, 32'h0, 2, 32'hA1B2_C3D4, 1'b0, "lw_100", ren_pat, wen_pat);
        applyStimulus(1'b0, 2'd1, 1'b0, 12'h102, 32'h0, 2, 32'hFFFF_C3D4, 1'b0, "lh_102", ren_pat, wen_pat);
        applyStimulus(1'b0, 2'd1, 1'b1, 12'h100, 32'h0, 2, 32'h0000_A1B2, 1'b0, "lhu_100", ren_pat, wen_pat);
        applyStimulus(1'b0, 2'd1, 1'b0, 12'h100, 32'h0, 2, 32'hFFFF_A1B2, 1'b0, "lh_100", ren_pat, wen_pat);

        // Sub-word store through read-modify-write
        applyStimulus(1'b1, 2'd0, 1'b0, 12'h102, 32'h1234_56EE, 3, 32'h0, 1'b0, "sb_102", ren_pat, wen_pat);
        checkOutput("sb_102_ren_pat", {29'h0, ren_pat}, 32'h1);
        checkOutput("sb_102_wen_pat", {29'h0, wen_pat}, 32'h2);
        checkOutput("sb_102_mem", mem[12'h100 >> 2], 32'hA1B2_EED4);
        applyStimulus(1'b1, 2'd1, 1'b0, 12'h106, 32'hCAFE_BEEF, 3, 32'h0, 1'b0, "sh_106", ren_pat, wen_pat);
        checkOutput("sh_106_mem", mem[12'h104 >> 2], 32'h1122_BEEF);

        // Misaligned and illegal-size accesses
        applyStimulus(1'b1, 2'd1, 1'b0, 12'h101, 32'hFFFF_FFFF, 1, 32'h0, 1'b1, "sh_101_err", ren_pat, wen_pat);
        checkOutput("sh_101_err_mem_pat", {29'h0, ren_pat | wen_pat}, 32'h0);
        applyStimulus(1'b0, 2'd2, 1'b0, 12'h106, 32'h0, 1, 32'h0, 1'b1, "lw_106_err", ren_pat, wen_pat);
        checkOutput("lw_106_err_mem_pat", {29'h0, ren_pat | wen_pat}, 32'h0);
        applyStimulus(1'b1, 2'd3, 1'b0, 12'h104, 32'h0, 1, 32'h0, 1'b1, "size3_err", ren_pat, wen_pat);
        checkOutput("err_mem_100", mem[12'h100 >> 2], 32'hA1B2_EED4);
        checkOutput("err_mem_104", mem[12'h104 >> 2], 32'h1122_BEEF);

        // Back-to-back with req_valid held: SW 0x200 then LW 0x200
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_we       = 1'b1;
        bus.req_size     = 2'd2;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 12'h200;
        bus.req_wdata    = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        bus.req_we    = 1'b0;
        bus.req_wdata = 32'h0;
        @(negedge clk);
        checkOutput("b2b_t1_ready", {31'h0, bus.req_ready}, 32'h0);
        checkOutput("b2b_t1_wen", {31'h0, bus.mem_wen}, 32'h1);
        checkOutput("b2b_t1_rsp", {31'h0, bus.rsp_valid}, 32'h0);
        @(negedge clk);
        checkOutput("b2b_t2_ready", {31'h0, bus.req_ready}, 32'h0);
        checkOutput("b2b_t2_rsp", {31'h0, bus.rsp_valid}, 32'h1);
        checkOutput("b2b_t2_rdata", bus.rsp_rdata, 32'h0);
        @(negedge clk);
        checkOutput("b2b_t3_ready", {31'h0, bus.req_ready}, 32'h1);
        checkOutput("b2b_t3_rsp", {31'h0, bus.rsp_valid}, 32'h0);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        checkOutput("b2b_t4_ren", {31'h0, bus.mem_ren}, 32'h1);
        checkOutput("b2b_t4_ready", {31'h0, bus.req_ready}, 32'h0);
        @(negedge clk);
        checkOutput("b2b_t5_rsp", {31'h0, bus.rsp_valid}, 32'h1);
        checkOutput("b2b_t5_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
        checkOutput("b2b_mem_200", mem[12'h200 >> 2], 32'hDEAD_BEEF);

        // Restore 0x100, then reset during RMW_RD of SB 0x100
        applyStimulus(1'b1, 2'd2, 1'b0, 12'h100, 32'hA1B2_C3D4, 2, 32'h0, 1'b0, "sw_100", ren_pat, wen_pat);
        checkOutput("sw_100_wen_pat", {29'h0, wen_pat}, 32'h1);
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_we       = 1'b1;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 12'h100;
        bus.req_wdata    = 32'h0000_0055;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        #1;
        checkOutput("rmw_ren_before_rst", {31'h0, bus.mem_ren}, 32'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("rmw_rst_ren", {31'h0, bus.mem_ren}, 32'h0);
        checkOutput("rmw_rst_wen", {31'h0, bus.mem_wen}, 32'h0);
        checkOutput("rmw_rst_add", {20'h0, bus.mem_add}, 32'h0);
        checkOutput("rmw_rst_rsp", {31'h0, bus.rsp_valid}, 32'h0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checkOutput("rmw_rst_hold_wen", {31'h0, bus.mem_wen}, 32'h0);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("rmw_post_rsp", {31'h0, bus.rsp_valid}, 32'h0);
            checkOutput("rmw_post_wen", {31'h0, bus.mem_wen}, 32'h0);
            checkOutput("rmw_post_ready", {31'h0, bus.req_ready}, 32'h1);
        end
        checkOutput("rmw_rst_mem_100", mem[12'h100 >> 2], 32'hA1B2_C3D4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store sequencer between the RV32I core's memory stage and the word-wide data memory (byte-addressed, combinational read, posedge write, 32-bit word only).
- Implements LB/LH/LW/LBU/LHU/SB/SH/SW.
- Sub-word stores are done as a read-modify-write (RMW), because the memory writes whole words only.
- Misaligned and illegal-size accesses are detected and reported without touching memory.

Parameters:
- ADDR_WIDTH, 12, byte address width of the data memory.
- DATA_WIDTH, 32, word width. Fixed at 32; any other value is unsupported.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  core presents an access
- req_ready  out  1  controller can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  funct3[1:0]: 0 = byte, 1 = half, 2 = word, 3 = illegal
- req_unsigned  in  1  funct3[2]: zero-extend loads
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned/illegal access, qualified by rsp_valid
- mem_ren  out  1  memory read enable
- mem_wen  out  1  memory write enable
- mem_add  out  ADDR_WIDTH  memory address, always word-aligned (bits [1:0] = 0)
- mem_datain  out  32  memory write data
- mem_dataout  in  32  memory read data, combinational

Behaviour:
- Lane map: byte offset k = addr[1:0] occupies mem word bits [31-8k : 24-8k].
  - Half at offset 0 uses bits [31:16]; half at offset 2 uses bits [15:0].
  - The byte at the lower address is more significant.
- Handshake: transfer when req_valid && req_ready. On transfer, req_we, size, unsigned, addr and wdata are registered. One outstanding access. No response back-pressure.
- FSM states: IDLE, LOAD, RMW_RD, WRITE, RESP.
  - IDLE:
    - req_ready = 1.
    - On transfer, decode. Misaligned means: half with addr[0] = 1, word with addr[1:0] != 0, or size = 3.
    - Misaligned -> RESP with err.
    - Load -> LOAD.
    - Store word -> WRITE.
    - Store byte/half -> RMW_RD.
  - LOAD:
    - mem_ren = 1, mem_add = aligned address.
    - Capture mem_dataout at the clock edge, then select the lane and sign- or zero-extend -> RESP.
  - RMW_RD:
    - mem_ren = 1.
    - Capture the word and merge the low 8/16 bits of wdata into the addressed lane -> WRITE.
  - WRITE:
    - mem_wen = 1 for exactly this cycle.
    - mem_datain = wdata (word store) or the merged word.
    - -> RESP.
  - RESP:
    - rsp_valid = 1, with rsp_rdata and rsp_err driven from registers.
    - -> IDLE.
- Latency (accept edge = cycle T):
  - error: rsp at T+1
  - load: rsp at T+2
  - word store: rsp at T+2
  - sub-word store: rsp at T+3
  - Next accept is possible the cycle after RESP.
- mem_ren and mem_wen are never both high. Outside LOAD/RMW_RD/WRITE: mem_add = 0, mem_datain = 0, mem_ren = 0, mem_wen = 0.
- Reset (asynchronous, any state):
  - state goes to IDLE.
  - rsp_valid = 0, rsp_err = 0, rsp_rdata = 0.
  - mem_wen = 0, mem_ren = 0, mem_add = 0, mem_datain = 0.
  - req_ready = 1 after release.
  - Reset asserted in RMW_RD, or in WRITE before the edge, leaves memory unmodified. The aborted access gives no response.
- Errored accesses never assert mem_ren or mem_wen.
- req_valid while not ready is ignored; the core holds the request.
- Address wrap: aligned address = addr & ~3, so no access crosses address 2^ADDR_WIDTH.

Test Plan:
1. Preload 0x100 = 0xA1B2C3D4.
   - LB 0x101 -> rsp_rdata 0xFFFFFFB2 at T+2.
   - LBU 0x101 -> 0x000000B2.
   - LW 0x100 -> 0xA1B2C3D4.
2. LH 0x102 -> 0xFFFFC3D4. LHU 0x100 -> 0x0000A1B2. rsp_err = 0 for both.
3. SB 0x102 wdata 0x123456EE:
   - mem_ren in T+1, mem_wen in T+2 only.
   - Word becomes 0xA1B2EED4. rsp_valid at T+3, rsp_rdata 0.
4. SH 0x101, then LW 0x104 with size = 2 and addr 0x106:
   - Each gives rsp_err = 1 at T+1.
   - mem_wen and mem_ren stay 0; memory unchanged.
5. Back-to-back accesses with req_valid held high:
   - SW 0x200 = 0xDEADBEEF, then LW 0x200 -> 0xDEADBEEF.
   - req_ready low from T+1 until RESP.
6. Drop rst_n during RMW_RD of SB 0x100 -> outputs reset immediately, no mem_wen, word still 0xA1B2C3D4, no rsp_valid.
